// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 control-port responder: default device
// address, FSM state codes, decoded-write record and the codec register map.
package wm8731_pkg;

  localparam logic [6:0] WM8731_DEV_ADDR = 7'b0011010;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ACK_A     = 3'd2;
  localparam logic [2:0] ST_B1        = 3'd3;
  localparam logic [2:0] ST_ACK_1     = 3'd4;
  localparam logic [2:0] ST_B2        = 3'd5;
  localparam logic [2:0] ST_ACK_2     = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  localparam logic [6:0] REG_LEFT_LINE_IN   = 7'h00;
  localparam logic [6:0] REG_RIGHT_LINE_IN  = 7'h01;
  localparam logic [6:0] REG_LEFT_HP_OUT    = 7'h02;
  localparam logic [6:0] REG_RIGHT_HP_OUT   = 7'h03;
  localparam logic [6:0] REG_ANALOG_PATH    = 7'h04;
  localparam logic [6:0] REG_DIGITAL_PATH   = 7'h05;
  localparam logic [6:0] REG_POWER_DOWN     = 7'h06;
  localparam logic [6:0] REG_DIGITAL_IF     = 7'h07;
  localparam logic [6:0] REG_SAMPLING       = 7'h08;
  localparam logic [6:0] REG_ACTIVE         = 7'h09;
  localparam logic [6:0] REG_RESET          = 7'h0F;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } reg_write_t;

  // True when the address byte selects this device for a write.
  function automatic logic is_own_write(input logic [7:0] addr_byte,
                                        input logic [6:0] dev_addr);
    return (addr_byte[7:1] == dev_addr) && !addr_byte[0];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock domain and derives bus edges and
// START/STOP conditions from the synchronized values only.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;
  logic                   sda_s;

  // Flops reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s       = scl_sync_q[SYNC_STAGES-1];
  assign sda_s       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o  = scl_s & ~scl_hist_q;
  assign scl_fall_o  = ~scl_s & scl_hist_q;
  assign start_det_o = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign sda_o       = sda_s;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// WM8731 control-port model: receives the 3-byte I2C register write, ACKs it
// and emits one decoded register write per completed transaction.
module wm8731_i2c_responder
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = WM8731_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       reg_wr,
  output logic       busy,
  output logic       addr_nack
);

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_s;

  logic [2:0] state_q, state_d;
  logic [6:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  reg_write_t hold_q, hold_d;
  logic       drive_q, drive_d;
  logic       commit_q, commit_d;
  logic       busy_q, busy_d;
  logic       nack_q, nack_d;
  logic [6:0] reg_addr_q;
  logic [8:0] reg_data_q;
  logic       reg_wr_q;

  logic [7:0] byte_in;
  logic       in_data_state;
  logic       byte_done;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (i2c_sclk),
    .sda_i      (i2c_sdat),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det),
    .sda_o      (sda_s)
  );

  assign i2c_sdat = drive_q ? 1'b0 : 1'bz;

  // The first seven bits are held; the eighth is taken live on its SCL rise.
  assign byte_in       = {shift_q, sda_s};
  assign in_data_state = (state_q == ST_ADDR) || (state_q == ST_B1) ||
                         (state_q == ST_B2)   || (state_q == ST_WAIT_STOP);
  assign byte_done     = scl_rise && in_data_state && (bitcnt_q == 3'd7);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    hold_d   = hold_q;
    drive_d  = drive_q;
    commit_d = 1'b0;
    busy_d   = busy_q;
    nack_d   = nack_q;

    if (scl_rise && in_data_state) begin
      shift_d  = byte_in[6:0];
      bitcnt_d = bitcnt_q + 3'd1;
    end

    case (state_q)
      ST_ADDR: begin
        if (byte_done) begin
          if (is_own_write(byte_in, DEV_ADDR)) begin
            state_d = ST_ACK_A;
          end else begin
            nack_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_B1: begin
        if (byte_done) begin
          hold_d.addr    = byte_in[7:1];
          hold_d.data[8] = byte_in[0];
          state_d        = ST_ACK_1;
        end
      end
      ST_B2: begin
        if (byte_done) begin
          hold_d.data[7:0] = byte_in;
          state_d          = ST_ACK_2;
        end
      end
      // First SCL fall pulls SDA low for the ACK slot, the second releases it.
      ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
        if (scl_fall) begin
          if (!drive_q) begin
            drive_d = 1'b1;
          end else begin
            drive_d = 1'b0;
            case (state_q)
              ST_ACK_A: state_d = ST_B1;
              ST_ACK_1: state_d = ST_B2;
              default: begin
                state_d  = ST_WAIT_STOP;
                commit_d = 1'b1;
              end
            endcase
          end
        end
      end
      default: ;
    endcase

    if (stop_det) begin
      state_d  = ST_IDLE;
      drive_d  = 1'b0;
      busy_d   = 1'b0;
      commit_d = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      bitcnt_d = 3'd0;
      drive_d  = 1'b0;
      busy_d   = 1'b1;
      nack_d   = 1'b0;
      commit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      hold_q   <= '0;
      drive_q  <= 1'b0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      hold_q   <= hold_d;
      drive_q  <= drive_d;
      commit_q <= commit_d;
      busy_q   <= busy_d;
      nack_q   <= nack_d;
    end
  end

  // Outputs update one cycle after the final ACK is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_addr_q <= '0;
      reg_data_q <= '0;
      reg_wr_q   <= 1'b0;
    end else begin
      reg_wr_q <= commit_q;
      if (commit_q) begin
        reg_addr_q <= hold_q.addr;
        reg_data_q <= hold_q.data;
      end
    end
  end

  assign reg_addr  = reg_addr_q;
  assign reg_data  = reg_data_q;
  assign reg_wr    = reg_wr_q;
  assign busy      = busy_q;
  assign addr_nack = nack_q;

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Bench for wm8731_i2c_responder: an I2C master drives directed and random
// packets; a scoreboard checks every decoded register write.
`timescale 1ns/1ps
module tb_wm8731_i2c_responder;
  import wm8731_pkg::*;

  localparam logic [6:0] DEV = WM8731_DEV_ADDR;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclDrv = 1'b1;
  logic       sdaDrv = 1'b0;
  wire        sdaLine;
  logic [6:0] regAddr;
  logic [8:0] regData;
  logic       regWr;
  logic       busy;
  logic       addrNack;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          quarter = 8;
  logic [7:0]  pkt [8];
  logic [15:0] expQ [$];
  logic [15:0] expWr;
  logic [6:0]  mdlAddr = '0;
  logic [8:0]  mdlData = '0;
  logic        prevWr = 1'b0;

  always #10 clk = ~clk;

  pullup(sdaLine);
  assign sdaLine = sdaDrv ? 1'b0 : 1'bz;

  wm8731_i2c_responder dut (
    .clk      (clk),
    .reset    (reset),
    .i2c_sclk (sclDrv),
    .i2c_sdat (sdaLine),
    .reg_addr (regAddr),
    .reg_data (regData),
    .reg_wr   (regWr),
    .busy     (busy),
    .addr_nack(addrNack)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitQ(input int n);
    repeat (n * quarter) @(posedge clk);
    #1;
  endtask

  task automatic i2cStart();
    if (!sclDrv) begin
      sdaDrv = 1'b0;
      waitQ(1);
      sclDrv = 1'b1;
      waitQ(2);
    end
    sdaDrv = 1'b1;
    waitQ(2);
    sclDrv = 1'b0;
    waitQ(1);
  endtask

  task automatic i2cBit(input logic v);
    sdaDrv = ~v;
    waitQ(1);
    sclDrv = 1'b1;
    waitQ(2);
    sclDrv = 1'b0;
    waitQ(1);
  endtask

  task automatic i2cAckClock(output logic ack);
    sdaDrv = 1'b0;
    waitQ(1);
    sclDrv = 1'b1;
    waitQ(1);
    ack = (sdaLine === 1'b0);
    waitQ(1);
    sclDrv = 1'b0;
    waitQ(1);
  endtask

  task automatic i2cByte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) i2cBit(b[i]);
    i2cAckClock(ack);
  endtask

  task automatic i2cStop();
    sdaDrv = 1'b1;
    waitQ(1);
    sclDrv = 1'b1;
    waitQ(2);
    sdaDrv = 1'b0;
    waitQ(2);
  endtask

  // Reference model: the device address byte alone decides acceptance; an
  // accepted transaction ACKs three bytes and commits one write.
  task automatic applyStimulus(input int n, input bit stopAfter);
    logic addrOk;
    logic ack;
    addrOk = (pkt[0] == {DEV, 1'b0});
    if (addrOk && n >= 3) begin
      mdlAddr = pkt[1][7:1];
      mdlData = {pkt[1][0], pkt[2]};
      expQ.push_back({mdlAddr, mdlData});
    end
    i2cStart();
    checkOutput("busy_after_start", busy, 1'b1);
    checkOutput("nack_cleared_by_start", addrNack, 1'b0);
    for (int i = 0; i < n; i++) begin
      i2cByte(pkt[i], ack);
      checkOutput($sformatf("ack_byte%0d", i), ack, addrOk && (i < 3));
      if (i == 0) checkOutput("addr_nack", addrNack, !addrOk);
    end
    if (stopAfter) begin
      i2cStop();
      checkOutput("busy_after_stop", busy, 1'b0);
    end
    checkOutput("reg_addr_held", regAddr, mdlAddr);
    checkOutput("reg_data_held", regData, mdlData);
  endtask

  task automatic setPkt(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    pkt[0] = b0;
    pkt[1] = b1;
    pkt[2] = b2;
    pkt[3] = b3;
  endtask

  // Scoreboard monitor: every reg_wr pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      prevWr = 1'b0;
    end else begin
      if (regWr) begin
        if (prevWr) begin
          checkOutput("reg_wr_width", prevWr, 1'b0);
        end else if (expQ.size() == 0) begin
          checkOutput("unexpected_reg_wr", regWr, 1'b0);
        end else begin
          expWr = expQ.pop_front();
          checkOutput("wr_reg_addr", regAddr, expWr[15:9]);
          checkOutput("wr_reg_data", regData, expWr[8:0]);
        end
      end
      prevWr = regWr;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] b;

    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_reg_addr", regAddr, 7'h00);
    checkOutput("rst_reg_data", regData, 9'h000);
    checkOutput("rst_reg_wr", regWr, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_addr_nack", addrNack, 1'b0);
    checkOutput("rst_sda_released", sdaLine, 1'b1);

    // 100 kHz SCL at 50 MHz: 500 clocks per SCL period.
    quarter = 125;
    setPkt(8'h34, 8'h1E, 8'h00, 8'h00);
    applyStimulus(3, 1'b1);
    quarter = 8;

    setPkt(8'h34, 8'h08, 8'h12, 8'h00);
    applyStimulus(3, 1'b1);
    setPkt(8'h35, 8'h00, 8'h01, 8'h00);
    applyStimulus(3, 1'b1);
    setPkt(8'h36, 8'h1E, 8'h00, 8'h00);
    applyStimulus(3, 1'b1);
    setPkt(8'h34, 8'h0C, 8'h00, 8'h00);
    applyStimulus(2, 1'b1);

    setPkt(8'h34, 8'h0C, 8'h00, 8'h00);
    applyStimulus(3, 1'b0);
    setPkt(8'h34, 8'h12, 8'h01, 8'hCC);
    applyStimulus(4, 1'b1);

    // Reset in the middle of the register byte aborts the transaction.
    i2cStart();
    i2cByte(8'h34, ack);
    checkOutput("rstmid_ack_addr", ack, 1'b1);
    b = 8'h1E;
    for (int i = 7; i >= 3; i--) i2cBit(b[i]);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rstmid_sda_released", sdaLine, 1'b1);
    checkOutput("rstmid_busy", busy, 1'b0);
    reset = 1'b0;
    mdlAddr = '0;
    mdlData = '0;
    for (int i = 2; i >= 0; i--) i2cBit(b[i]);
    i2cAckClock(ack);
    checkOutput("rstmid_ack_ignored", ack, 1'b0);
    i2cStop();
    checkOutput("rstmid_busy_after_stop", busy, 1'b0);
    checkOutput("rstmid_reg_addr", regAddr, 7'h00);

    setPkt(8'h34, 8'h1E, 8'h00, 8'h00);
    applyStimulus(3, 1'b1);

    for (int t = 0; t < 8; t++) begin
      b = ($urandom_range(0, 3) != 0) ? {DEV, 1'b0} : 8'($urandom);
      setPkt(b, 8'($urandom), 8'($urandom), 8'($urandom));
      applyStimulus($urandom_range(2, 4), 1'b1);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("pending_writes", 16'(expQ.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
